truth_table_extractor: RTL and testbench

- Characterisation engine for 3-input combinational logic blocks (wolfram-coded gates such as m0xC4).
- Inverse of a truth-table gate: it drives every input combination into a device under characterisation and waits a settle time at each vector.
- It samples the device's single output and reassembles the 8-bit wolfram code.
- Sits beside gate instances in characterisation and self-check benches, and in on-chip library verification.

---
 rtl/truth_pkg.sv | 18 +
 rtl/settle_timer.sv | 35 +++
 rtl/truth_table_extractor.sv | 132 +++++++++++++
 tb/tb_truth_table_extractor.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/truth_pkg.sv
// Shared types and constants for the truth-table characterisation engines.
package truth_pkg;

  localparam int N_IN   = 3;
  localparam int CODE_W = 1 << N_IN;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Vector 000 lands in the MSB of the wolfram code, vector 111 in the LSB.
  function automatic logic [N_IN-1:0] code_bit_index(input logic [N_IN-1:0] idx);
    return N_IN'(CODE_W - 1) - idx;
  endfunction

endpackage

// File: rtl/settle_timer.sv
// Reloadable down-counter; expire pulses on the last cycle of each settle window.
module settle_timer #(
  parameter int           W        = 8,
  parameter logic [W-1:0] LOAD_VAL = '0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic expire
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = LOAD_VAL;
    end else if (en) begin
      count_d = (count_q == '0) ? LOAD_VAL : count_q - W'(1);
    end
  end

  assign expire = en && !load && (count_q == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/truth_table_extractor.sv
// Sweeps all 3-input vectors into a device, samples its output after a settle
// window per vector, and reassembles the 8-bit wolfram code.
module truth_table_extractor
  import truth_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [CODE_W-1:0] expected,
  output logic              probe_in1,
  output logic              probe_in2,
  output logic              probe_in3,
  input  logic              probe_out,
  output logic              busy,
  output logic              done,
  output logic [CODE_W-1:0] code,
  output logic              code_valid,
  output logic              match,
  output state_t            state_dbg
);

  localparam logic [N_IN-1:0] LAST_IDX = N_IN'(CODE_W - 1);
  localparam logic [7:0]      SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

  state_t            state_q, state_d;
  logic [N_IN-1:0]   idx_q, idx_d;
  logic [N_IN-1:0]   probe_q, probe_d;
  logic [CODE_W-1:0] shadow_q, shadow_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic              code_valid_q, code_valid_d;
  logic              match_q, match_d;
  logic              timer_load;
  logic              timer_en;
  logic              timer_expire;

  settle_timer #(
    .W        (8),
    .LOAD_VAL (SETTLE_LOAD)
  ) u_settle_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (timer_load),
    .en     (timer_en),
    .expire (timer_expire)
  );

  assign timer_en = (state_q == DRIVE);

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    probe_d      = probe_q;
    shadow_d     = shadow_q;
    code_d       = code_q;
    code_valid_d = code_valid_q;
    match_d      = match_q;
    timer_load   = 1'b0;
    case (state_q)
      IDLE: begin
        probe_d = '0;
        // abort wins over start so a stuck abort line can never launch a sweep
        if (start && !abort) begin
          state_d      = DRIVE;
          idx_d        = '0;
          shadow_d     = '0;
          code_valid_d = 1'b0;
          match_d      = 1'b0;
          timer_load   = 1'b1;
        end
      end
      DRIVE: begin
        if (abort) begin
          state_d = IDLE;
          idx_d   = '0;
          probe_d = '0;
        end else if (timer_expire) begin
          shadow_d[code_bit_index(idx_q)] = probe_out;
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
            idx_d   = '0;
            probe_d = '0;
          end else begin
            idx_d   = idx_q + N_IN'(1);
            probe_d = idx_q + N_IN'(1);
          end
        end
      end
      DONE: begin
        code_d       = shadow_q;
        code_valid_d = 1'b1;
        match_d      = (shadow_q == expected);
        state_d      = IDLE;
      end
      default: begin
        state_d = IDLE;
        probe_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      probe_q      <= '0;
      shadow_q     <= '0;
      code_q       <= '0;
      code_valid_q <= 1'b0;
      match_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      probe_q      <= probe_d;
      shadow_q     <= shadow_d;
      code_q       <= code_d;
      code_valid_q <= code_valid_d;
      match_q      <= match_d;
    end
  end

  assign {probe_in1, probe_in2, probe_in3} = probe_q;
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign code       = code_q;
  assign code_valid = code_valid_q;
  assign match      = match_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_truth_table_extractor.sv
// Bench for truth_table_extractor: behavioural device model driven by the probes,
// scoreboard of expected codes popped when each sweep completes.
module tb_truth_table_extractor;
  import truth_pkg::*;

  localparam int S     = 4;
  localparam int SWEEP = 8 * S;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic [7:0]   expected = 8'h00;
  logic         probe_in1, probe_in2, probe_in3;
  logic         probe_out;
  logic         busy, done, code_valid, match;
  logic [7:0]   code;
  state_t       state_dbg;

  logic [7:0]   model_code = 8'h00;
  logic [2:0]   vec;
  logic [7:0]   exp_q[$];
  int           n_cmp = 0;
  int           n_err = 0;

  assign vec       = {probe_in1, probe_in2, probe_in3};
  assign probe_out = model_code[3'd7 - vec];

  always #5 clk = ~clk;

  truth_table_extractor #(.SETTLE_CYCLES(S)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .expected   (expected),
    .probe_in1  (probe_in1),
    .probe_in2  (probe_in2),
    .probe_in3  (probe_in3),
    .probe_out  (probe_out),
    .busy       (busy),
    .done       (done),
    .code       (code),
    .code_valid (code_valid),
    .match      (match),
    .state_dbg  (state_dbg)
  );

  // Full sweep from the start pulse to one cycle after done, checked per cycle.
  task automatic run_sweep(input logic [7:0] model, input logic [7:0] ref_code, input bit hold);
    logic [7:0] want;
    logic [2:0] exp_vec;
    logic       exp_match;
    model_code = model;
    expected   = ref_code;
    exp_match  = (model == ref_code);
    exp_q.push_back(model);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    if (!hold) start = 1'b0;
    for (int c = 1; c <= SWEEP + 1; c++) begin
      exp_vec = (c <= SWEEP) ? 3'((c - 1) / S) : 3'd0;
      n_cmp++;
      if (busy !== 1'b1) begin
        n_err++;
        $display("FAIL sweep_busy cycle %0d: got %b want 1", c, busy);
      end
      n_cmp++;
      if (vec !== exp_vec) begin
        n_err++;
        $display("FAIL sweep_probe cycle %0d: got %b want %b", c, vec, exp_vec);
      end
      n_cmp++;
      if (done !== (c == SWEEP + 1)) begin
        n_err++;
        $display("FAIL sweep_done cycle %0d: got %b want %b", c, done, (c == SWEEP + 1));
      end
      @(negedge clk);
    end
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || vec !== 3'b000) begin
      n_err++;
      $display("FAIL sweep_idle: got busy=%b done=%b vec=%b want 0/0/000", busy, done, vec);
    end
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL sweep_code: got %h, scoreboard empty", code);
    end else begin
      want = exp_q.pop_front();
      if (code !== want) begin
        n_err++;
        $display("FAIL sweep_code: got %h want %h", code, want);
      end
    end
    n_cmp++;
    if (code_valid !== 1'b1 || match !== exp_match) begin
      n_err++;
      $display("FAIL sweep_valid_match: got valid=%b match=%b want 1/%b", code_valid, match, exp_match);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || code !== 8'h00 || code_valid !== 1'b0 ||
        match !== 1'b0 || vec !== 3'b000 || state_dbg !== IDLE) begin
      n_err++;
      $display("FAIL reset: got busy=%b done=%b code=%h valid=%b match=%b vec=%b want all 0",
               busy, done, code, code_valid, match, vec);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_c4();
    run_sweep(8'hC4, 8'hC4, 1'b0);
  endtask

  task automatic test_models();
    logic [7:0] models [4];
    models = '{8'h00, 8'hFF, 8'h0F, 8'h55};
    for (int i = 0; i < 4; i++) run_sweep(models[i], 8'hC4, 1'b0);
  endtask

  task automatic test_start_abort_idle();
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (busy !== 1'b0 || vec !== 3'b000) begin
        n_err++;
        $display("FAIL start_abort_idle %0d: got busy=%b vec=%b want 0/000", i, busy, vec);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_abort();
    int pulses;
    model_code = 8'h0F;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || vec !== 3'b000 || code_valid !== 1'b0) begin
      n_err++;
      $display("FAIL abort_idle: got busy=%b done=%b vec=%b valid=%b want 0/0/000/0",
               busy, done, vec, code_valid);
    end
    pulses = 0;
    for (int i = 0; i < SWEEP + 8; i++) begin
      if (done === 1'b1) pulses++;
      @(negedge clk);
    end
    n_cmp++;
    if (pulses != 0 || code_valid !== 1'b0) begin
      n_err++;
      $display("FAIL abort_no_done: got pulses=%0d valid=%b want 0/0", pulses, code_valid);
    end
    run_sweep(8'hC4, 8'hC4, 1'b0);
  endtask

  task automatic test_start_hold();
    int pulses;
    logic [7:0] want;
    run_sweep(8'hC4, 8'hC4, 1'b1);
    exp_q.push_back(8'hC4);
    @(negedge clk);
    start = 1'b0;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL hold_second_sweep: got busy=%b want 1", busy);
    end
    pulses = 0;
    for (int i = 0; i < 2 * SWEEP; i++) begin
      if (done === 1'b1) pulses++;
      @(negedge clk);
    end
    n_cmp++;
    if (pulses != 1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL hold_one_done: got pulses=%0d busy=%b want 1/0", pulses, busy);
    end
    n_cmp++;
    want = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
    if (code !== want || code_valid !== 1'b1 || match !== 1'b1) begin
      n_err++;
      $display("FAIL hold_code: got %h valid=%b match=%b want %h/1/1", code, code_valid, match, want);
    end
  endtask

  task automatic test_reset_mid();
    model_code = 8'hFF;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || code !== 8'h00 || code_valid !== 1'b0 ||
        match !== 1'b0 || vec !== 3'b000) begin
      n_err++;
      $display("FAIL reset_mid: got busy=%b done=%b code=%h valid=%b match=%b vec=%b want all 0",
               busy, done, code, code_valid, match, vec);
    end
    rst_n = 1'b1;
    run_sweep(8'h55, 8'h55, 1'b0);
  endtask

  initial begin
    test_reset();
    test_c4();
    test_models();
    test_start_abort_idle();
    test_abort();
    test_start_hold();
    test_reset_mid();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d entries want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
